// File: rtl/life_pkg.sv
// Shared Game-of-Life definitions: grid geometry and the display scanner's state encoding.
package life_pkg;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_BLANK = 2'd2,
        S_DRIVE = 2'd3
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/life_grid_scanner_timer.sv
// Down-counter shared by the BLANK and DRIVE phases; done is high while the count is zero.
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority so a phase change can reload in the same cycle the old phase ends.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/life_grid_scanner.sv
// Row-multiplexed LED driver for the cell grid: snapshots the grid per frame and scans rows.
module life_grid_scanner
    import life_pkg::*;
#(
    parameter int ROWS  = GRID_ROWS,
    parameter int COLS  = GRID_COLS,
    parameter int DWELL = 1024,
    parameter int BLANK = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [ROWS*COLS-1:0]    grid,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_data,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    frame_start,
    output logic                    busy
);

    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(max_int(DWELL, BLANK) + 1);

    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LOAD = (BLANK > 0) ? TW'(BLANK - 1) : '0;
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    // Every row starts with its blanking gap, or straight in DRIVE when blanking is disabled.
    localparam scan_state_t   ROW_ENTRY      = (BLANK > 0) ? S_BLANK : S_DRIVE;
    localparam logic [TW-1:0] ROW_ENTRY_LOAD = (BLANK > 0) ? BLANK_LOAD : DWELL_LOAD;

    scan_state_t            state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [ROWS*COLS-1:0]   snapshot_q, snapshot_d;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_value;
    logic                   tmr_enable;
    logic                   tmr_done;

    logic [ROWS-1:0]        row_sel_d;
    logic [COLS-1:0]        col_data_d;
    logic                   frame_start_d;
    logic                   busy_d;

    scan_timer #(
        .WIDTH(TW)
    ) u_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (tmr_load),
        .enable    (tmr_enable),
        .load_value(tmr_value),
        .done      (tmr_done)
    );

    assign tmr_enable = (state_q == S_BLANK) || (state_q == S_DRIVE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            snapshot_q  <= '0;
            row_sel     <= '0;
            col_data    <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            snapshot_q  <= snapshot_d;
            row_sel     <= row_sel_d;
            col_data    <= col_data_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
        end
    end

    // row_q is forced to zero whenever the scanner goes idle, so it doubles as row_idx.
    assign row_idx = row_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        snapshot_d = snapshot_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                snapshot_d = grid;
                row_d      = '0;
                state_d    = ROW_ENTRY;
                tmr_load   = 1'b1;
                tmr_value  = ROW_ENTRY_LOAD;
            end
            S_BLANK: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end else if (tmr_done) begin
                    state_d   = S_DRIVE;
                    tmr_load  = 1'b1;
                    tmr_value = DWELL_LOAD;
                end
            end
            S_DRIVE: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end else if (tmr_done) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        row_d     = row_q + 1'b1;
                        state_d   = ROW_ENTRY;
                        tmr_load  = 1'b1;
                        tmr_value = ROW_ENTRY_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase

        // Outputs are computed from the next state so the registered copies line up with it.
        frame_start_d = (state_d == S_LOAD);
        busy_d        = (state_d != S_IDLE);
        row_sel_d     = '0;
        col_data_d    = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ((state_d == S_DRIVE) && (row_d == RW'(r))) begin
                row_sel_d[r] = 1'b1;
                col_data_d   = snapshot_d[r*COLS +: COLS];
            end
        end
    end

endmodule

// File: tb/tb_life_grid_scanner.sv
// Directed bench for life_grid_scanner: 4x4 grid with blanking, plus a no-blank single-cycle-dwell instance.
module tb_life_grid_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DWELL = 3;
    localparam int BLANK = 2;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        reset_a, enable_a;
    logic [15:0] grid_a;
    logic [3:0]  row_sel_a, col_data_a;
    logic [1:0]  row_idx_a;
    logic        frame_start_a, busy_a;

    logic        reset_b, enable_b;
    logic [15:0] grid_b;
    logic [3:0]  row_sel_b, col_data_b;
    logic [1:0]  row_idx_b;
    logic        frame_start_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    life_grid_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)
    ) dut_a (
        .Clock      (Clock),
        .Reset      (reset_a),
        .Enable     (enable_a),
        .grid       (grid_a),
        .row_sel    (row_sel_a),
        .col_data   (col_data_a),
        .row_idx    (row_idx_a),
        .frame_start(frame_start_a),
        .busy       (busy_a)
    );

    life_grid_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(1), .BLANK(0)
    ) dut_b (
        .Clock      (Clock),
        .Reset      (reset_b),
        .Enable     (enable_b),
        .grid       (grid_b),
        .row_sel    (row_sel_b),
        .col_data   (col_data_b),
        .row_idx    (row_idx_b),
        .frame_start(frame_start_b),
        .busy       (busy_b)
    );

    // Row strobes must never select more than one row on either instance.
    always @(negedge Clock) begin
        n_checks++;
        assert ($onehot0(row_sel_a) && $onehot0(row_sel_b)) else begin
            n_errors++;
            $error("FAIL onehot: observed row_sel_a=%h row_sel_b=%h, expected zero or one-hot", row_sel_a, row_sel_b);
        end
    end

    task automatic step();
        @(negedge Clock);
    endtask

    // Packed layout: {row_sel[3:0], col_data[3:0], row_idx[1:0], frame_start, busy}
    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed row_sel=%h col_data=%h row_idx=%0d frame_start=%b busy=%b, expected row_sel=%h col_data=%h row_idx=%0d frame_start=%b busy=%b",
                   tag, obs[11:8], obs[7:4], obs[3:2], obs[1], obs[0],
                   exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] rs, input logic [3:0] cd,
                         input logic [1:0] ri, input logic fs, input logic b);
        chk(tag, {row_sel_a, col_data_a, row_idx_a, frame_start_a, busy_a}, {rs, cd, ri, fs, b});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] rs, input logic [3:0] cd,
                         input logic [1:0] ri, input logic fs, input logic b);
        chk(tag, {row_sel_b, col_data_b, row_idx_b, frame_start_b, busy_b}, {rs, cd, ri, fs, b});
    endtask

    task automatic load_a();
        step();
        chk_a("load", 4'h0, 4'h0, 2'd0, 1'b1, 1'b1);
    endtask

    task automatic idle_a(input string tag);
        step();
        chk_a(tag, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic blank_a(input int r);
        for (int i = 0; i < BLANK; i++) begin
            step();
            chk_a("blank", 4'h0, 4'h0, 2'(r), 1'b0, 1'b1);
        end
    endtask

    task automatic drive_a(input int r, input logic [3:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk_a("drive", 4'(1 << r), val, 2'(r), 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset_a  = 1'b1;
        enable_a = 1'b0;
        grid_a   = 16'h0000;
        reset_b  = 1'b1;
        enable_b = 1'b0;
        grid_b   = 16'hFFFF;

        repeat (3) step();
        chk_a("reset", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        reset_a = 1'b0;

        // Cycle 0: idle, then enable with the first image.
        idle_a("idle");
        grid_a   = 16'hA5C3;
        enable_a = 1'b1;

        // Frame 1: LOAD at cycle 1; grid changes mid-frame must not show until the next frame.
        load_a();
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'hA);
        for (int r = 0; r < ROWS; r++) begin
            blank_a(r);
            drive_a(r, exp_q.pop_front(), DWELL);
            if (r == 1) grid_a = 16'hFFFF;
        end

        // Frame 2: LOAD at cycle 22, new snapshot; abort during row 2.
        load_a();
        for (int r = 0; r < 2; r++) begin
            blank_a(r);
            drive_a(r, 4'hF, DWELL);
        end
        blank_a(2);
        drive_a(2, 4'hF, 1);
        enable_a = 1'b0;
        idle_a("abort");
        idle_a("idle_hold");
        enable_a = 1'b1;

        // Restart from row 0, then a one-cycle reset during row 3.
        load_a();
        for (int r = 0; r < 3; r++) begin
            blank_a(r);
            drive_a(r, 4'hF, DWELL);
        end
        blank_a(3);
        drive_a(3, 4'hF, 1);
        reset_a = 1'b1;
        idle_a("reset_mid");
        reset_a = 1'b0;
        load_a();
        blank_a(0);
        drive_a(0, 4'hF, DWELL);

        // No blanking, single-cycle dwell: rows on consecutive cycles, 5-cycle frame.
        reset_b = 1'b0;
        step();
        chk_b("b_idle", 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        enable_b = 1'b1;
        step();
        chk_b("b_load", 4'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        for (int r = 0; r < ROWS; r++) begin
            step();
            chk_b("b_drive", 4'(1 << r), 4'hF, 2'(r), 1'b0, 1'b1);
        end
        step();
        chk_b("b_load2", 4'h0, 4'h0, 2'd0, 1'b1, 1'b1);
        step();
        chk_b("b_drive2", 4'h1, 4'hF, 2'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
